// File: rtl/core_wb_pkg.sv
// Shared encodings for the writeback sequencer: result kinds, FSM states, default load timeout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_wb_pkg;

  // RES_KIND encodings
  localparam logic [1:0] KIND_ALU   = 2'd0;
  localparam logic [1:0] KIND_LOAD  = 2'd1;
  localparam logic [1:0] KIND_INPUT = 2'd2;
  localparam logic [1:0] KIND_NONE  = 2'd3;

  // Cycles to wait for load data before giving up
  localparam int unsigned LOAD_TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_MEM = 3'd1,
    ST_WAIT_RX  = 3'd2,
    ST_WRITE    = 3'd3,
    ST_HOLD     = 3'd4
  } state_t;

  // Integer register 0 is hardwired; a write there must not raise WE.
  // FP rd=0 is harmless because its address steers to 0 anyway.
  function automatic logic wr_effective(input logic is_fp, input logic [4:0] rd);
    return is_fp || (rd != 5'd0);
  endfunction

endpackage

// File: rtl/core_wb_timeout.sv
// Load-wait counter: clears on load acceptance, counts wait cycles, flags the final allowed cycle.
// Latency: at_limit is combinational from the registered count.
// Backpressure: none; en/clr are sampled every cycle.
module core_wb_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic at_limit
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt_d;
  logic [7:0] cnt_q;

  // Next count: clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // This wait cycle is the last one allowed; no data now means abort
  assign at_limit = (cnt_q == LAST);

endmodule

// File: rtl/core_wb.sv
// Writeback sequencer in front of the register file (optional forwarding outputs under CORE_WB_BYPASS_EN).
// Latency: ALU 3 cycles (IDLE, WRITE, HOLD); LOAD 3 + memory wait; INPUT 1 + RX wait; NONE retires next cycle.
// Backpressure: RES_READY high only in IDLE; RX_READY pulses combinationally when a byte is taken.
module core_wb
  import core_wb_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = LOAD_TIMEOUT_DEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RES_VALID,
  output logic        RES_READY,
  input  logic [1:0]  RES_KIND,
  input  logic [4:0]  RES_RD,
  input  logic        RES_IS_FP,
  input  logic [31:0] RES_DATA,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  input  logic        RX_VALID,
  input  logic [7:0]  RX_DATA,
  output logic        RX_READY,
  output logic        WE,
  output logic [4:0]  WADDR,
  output logic [4:0]  FWADDR,
  output logic [31:0] WDATA,
  output logic        INE,
  output logic [7:0]  INDATA,
  output logic        DONE,
  output logic        ERR
`ifdef CORE_WB_BYPASS_EN
  ,
  output logic        BYP_VALID,
  output logic [5:0]  BYP_RD,
  output logic [31:0] BYP_DATA
`endif
);

  state_t      state_d, state_q;
  logic [4:0]  rd_d, rd_q;
  logic        fp_d, fp_q;
  logic [31:0] wdata_d, wdata_q;
  logic        rdy_d, rdy_q;
  logic        we_d, we_q;
  logic [4:0]  waddr_d, waddr_q;
  logic [4:0]  fwaddr_d, fwaddr_q;
  logic        done_d, done_q;
  logic        err_d, err_q;
  logic        active_d;
  logic        wr_ok_d;
  logic        res_xfer;
  logic        rx_take;
  logic        tmo_clr;
  logic        tmo_en;
  logic        tmo_at_limit;
`ifdef CORE_WB_BYPASS_EN
  logic        byp_vld_d, byp_vld_q;
`endif

  assign res_xfer = RES_VALID && rdy_q;
  assign rx_take  = (state_q == ST_WAIT_RX) && RX_VALID;

  core_wb_timeout #(
    .LIMIT (LOAD_TIMEOUT)
  ) u_timeout (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clr      (tmo_clr),
    .en       (tmo_en),
    .at_limit (tmo_at_limit)
  );

  // Next state, captured operands and next values of every registered output
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    fp_d    = fp_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = err_q;
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (res_xfer) begin
          rd_d    = RES_RD;
          fp_d    = RES_IS_FP;
          wdata_d = 32'd0;
          case (RES_KIND)
            KIND_ALU: begin
              wdata_d = RES_DATA;
              state_d = ST_WRITE;
            end
            KIND_LOAD: begin
              tmo_clr = 1'b1;
              state_d = ST_WAIT_MEM;
            end
            KIND_INPUT: begin
              state_d = ST_WAIT_RX;
            end
            default: begin
              done_d = 1'b1;
            end
          endcase
        end
      end
      ST_WAIT_MEM: begin
        // Data arriving on the final allowed cycle still counts
        if (MEM_RVALID) begin
          wdata_d = MEM_RDATA;
          state_d = ST_WRITE;
        end else begin
          tmo_en = 1'b1;
          if (tmo_at_limit) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_RX: begin
        if (RX_VALID) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        done_d  = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs follow the state being entered so they are glitch-free registers
    active_d = (state_d != ST_IDLE);
    wr_ok_d  = wr_effective(fp_d, rd_d);
    rdy_d    = !active_d;
    we_d     = (state_d == ST_WRITE) && wr_ok_d;
    waddr_d  = (active_d && !fp_d) ? rd_d : 5'd0;
    fwaddr_d = (active_d && fp_d) ? rd_d : 5'd0;
    if (!active_d) begin
      wdata_d = 32'd0;
    end
`ifdef CORE_WB_BYPASS_EN
    byp_vld_d = ((state_d == ST_WRITE) || (state_d == ST_HOLD)) && wr_ok_d;
`endif
  end

  // FSM state, captured operands and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      rd_q      <= 5'd0;
      fp_q      <= 1'b0;
      wdata_q   <= 32'd0;
      rdy_q     <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= 5'd0;
      fwaddr_q  <= 5'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef CORE_WB_BYPASS_EN
      byp_vld_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      fp_q      <= fp_d;
      wdata_q   <= wdata_d;
      rdy_q     <= rdy_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      fwaddr_q  <= fwaddr_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef CORE_WB_BYPASS_EN
      byp_vld_q <= byp_vld_d;
`endif
    end
  end

  assign RES_READY = rdy_q;
  assign WE        = we_q;
  assign WADDR     = waddr_q;
  assign FWADDR    = fwaddr_q;
  assign WDATA     = wdata_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

  // Byte insert happens in the very cycle the byte is taken
  assign RX_READY  = rx_take;
  assign INE       = rx_take;
  assign INDATA    = rx_take ? RX_DATA : 8'd0;

`ifdef CORE_WB_BYPASS_EN
  assign BYP_VALID = byp_vld_q;
  assign BYP_RD    = {fp_q, rd_q};
  assign BYP_DATA  = wdata_q;
`endif

endmodule

// File: tb/tb_core_wb.sv
// Directed bench for core_wb with a write scoreboard and a negedge monitor.
// Latency: n/a.
// Backpressure: waits on RES_READY with a bounded cycle budget.
module tb_core_wb;

  localparam logic [1:0] K_ALU   = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_INPUT = 2'd2;
  localparam logic [1:0] K_NONE  = 2'd3;
  localparam int TMO = 12;

  logic        CLK, RST_N;
  logic        RES_VALID, RES_READY;
  logic [1:0]  RES_KIND;
  logic [4:0]  RES_RD;
  logic        RES_IS_FP;
  logic [31:0] RES_DATA;
  logic        MEM_RVALID;
  logic [31:0] MEM_RDATA;
  logic        RX_VALID;
  logic [7:0]  RX_DATA;
  logic        RX_READY, WE, INE, DONE, ERR;
  logic [4:0]  WADDR, FWADDR;
  logic [31:0] WDATA;
  logic [7:0]  INDATA;

  typedef struct {
    logic        ine;
    logic [4:0]  waddr;
    logic [4:0]  fwaddr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t hold_exp;
  logic hold_pend;
  int   checks;
  int   failures;
  int   done_cnt;

  core_wb #(.LOAD_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_KIND(RES_KIND),
    .RES_RD(RES_RD), .RES_IS_FP(RES_IS_FP), .RES_DATA(RES_DATA),
    .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA),
    .RX_VALID(RX_VALID), .RX_DATA(RX_DATA), .RX_READY(RX_READY),
    .WE(WE), .WADDR(WADDR), .FWADDR(FWADDR), .WDATA(WDATA),
    .INE(INE), .INDATA(INDATA), .DONE(DONE), .ERR(ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic ine, input logic [4:0] wa, input logic [4:0] fwa, input logic [31:0] d);
    exp_t e;
    e.ine = ine; e.waddr = wa; e.fwaddr = fwa; e.data = d;
    sb.push_back(e);
  endtask

  // Present one instruction, let it transfer, then scramble the operand buses
  task automatic issue(input logic [1:0] k, input logic [4:0] rd, input logic fp, input logic [31:0] d);
    int n;
    n = 0;
    while (RES_READY !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("ready_before_issue", RES_READY, 1);
    RES_VALID = 1'b1; RES_KIND = k; RES_RD = rd; RES_IS_FP = fp; RES_DATA = d;
    tick();
    RES_VALID = 1'b0;
    RES_RD    = 5'($urandom);
    RES_IS_FP = 1'($urandom);
    RES_DATA  = $urandom;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (DONE !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  // Monitor: every WE/INE must match the oldest expected write; WE data must hold one more cycle
  always @(negedge CLK) begin
    exp_t e;
    if (hold_pend) begin
      chk("hold_we_low", WE, 0);
      chk("hold_done", DONE, 1);
      chk("hold_waddr", WADDR, hold_exp.waddr);
      chk("hold_fwaddr", FWADDR, hold_exp.fwaddr);
      chk("hold_wdata", WDATA, hold_exp.data);
      hold_pend = 1'b0;
    end
    if (WE === 1'b1 || INE === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {WE, INE}, 0);
      end else begin
        e = sb.pop_front();
        chk("we_ine_exclusive", WE & INE, 0);
        chk("write_kind_ine", INE, e.ine);
        chk("write_waddr", WADDR, e.waddr);
        chk("write_fwaddr", FWADDR, e.fwaddr);
        if (e.ine) begin
          chk("ins_data", INDATA, e.data[7:0]);
          chk("ins_rx_ready", RX_READY, 1);
        end else begin
          chk("write_wdata", WDATA, e.data);
          hold_exp  = e;
          hold_pend = 1'b1;
        end
      end
    end
    if (DONE === 1'b1) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    checks = 0; failures = 0; done_cnt = 0; hold_pend = 1'b0;
    RST_N = 1'b0; RES_VALID = 1'b0; RES_KIND = K_NONE; RES_RD = 5'd0; RES_IS_FP = 1'b0;
    RES_DATA = 32'd0; MEM_RVALID = 1'b0; MEM_RDATA = 32'd0; RX_VALID = 1'b0; RX_DATA = 8'd0;

    // Reset state
    #1;
    chk("reset_outputs", {RES_READY, RX_READY, WE, WADDR, FWADDR, WDATA, INE, INDATA, DONE, ERR}, 0);
    repeat (3) @(posedge CLK);
    #3 RST_N = 1'b1;
    tick();
    chk("ready_after_reset", RES_READY, 1);

    // ALU int rd=5: WE one cycle, DONE on third cycle, ready low two cycles
    push(1'b0, 5'd5, 5'd0, 32'hDEADBEEF);
    issue(K_ALU, 5'd5, 1'b0, 32'hDEADBEEF);
    chk("alu_we", WE, 1);
    chk("alu_ready_low1", RES_READY, 0);
    chk("alu_done_early", DONE, 0);
    tick();
    chk("alu_ready_low2", RES_READY, 0);
    chk("alu_done", DONE, 1);
    tick();
    chk("alu_idle_ready", {RES_READY, DONE, WE}, 3'b100);

    // LOAD fp rd=3, data after 10 wait cycles
    push(1'b0, 5'd0, 5'd3, 32'h3F800000);
    issue(K_LOAD, 5'd3, 1'b1, 32'h0);
    chk("load_fwaddr_wait", {FWADDR, WADDR}, {5'd3, 5'd0});
    repeat (9) tick();
    MEM_RVALID = 1'b1; MEM_RDATA = 32'h3F800000;
    tick();
    MEM_RVALID = 1'b0; MEM_RDATA = $urandom;
    chk("load_we", WE, 1);
    wait_done(5, n);
    chk("load_done", DONE, 1);
    chk("load_err_clear", ERR, 0);
    tick();

    // LOAD whose data lands on the final allowed wait cycle: data wins
    push(1'b0, 5'd9, 5'd0, 32'hCAFEF00D);
    issue(K_LOAD, 5'd9, 1'b0, 32'h0);
    repeat (TMO - 1) tick();
    MEM_RVALID = 1'b1; MEM_RDATA = 32'hCAFEF00D;
    tick();
    MEM_RVALID = 1'b0;
    chk("edge_load_we", {WE, DONE}, 2'b10);
    wait_done(5, n);
    tick();
    chk("edge_load_err", ERR, 0);

    // LOAD that never gets data: no write, DONE after TMO wait cycles, ERR sticky
    d0 = done_cnt;
    issue(K_LOAD, 5'd7, 1'b0, 32'h0);
    wait_done(TMO + 5, n);
    chk("tmo_wait_cycles", n, TMO);
    chk("tmo_err", ERR, 1);
    tick();
    chk("tmo_done_once", done_cnt - d0, 1);

    // INPUT int rd=10, byte after 4 cycles
    push(1'b1, 5'd10, 5'd0, 32'h41);
    issue(K_INPUT, 5'd10, 1'b0, 32'h0);
    repeat (3) tick();
    chk("rx_ready_idle", RX_READY, 0);
    RX_VALID = 1'b1; RX_DATA = 8'h41;
    #1;
    chk("rx_take", {RX_READY, INE, INDATA, WADDR, WE}, {1'b1, 1'b1, 8'h41, 5'd10, 1'b0});
    tick();
    RX_VALID = 1'b0;
    chk("rx_done", {DONE, INE}, 2'b10);

    // ALU int rd=0: no WE, still DONE
    d0 = done_cnt;
    issue(K_ALU, 5'd0, 1'b0, 32'h12345678);
    chk("rd0_we_write", WE, 0);
    tick();
    chk("rd0_done", DONE, 1);
    tick();

    // ALU fp rd=0: WE allowed but both addresses 0
    push(1'b0, 5'd0, 5'd0, 32'h55AA55AA);
    issue(K_ALU, 5'd0, 1'b1, 32'h55AA55AA);
    chk("fp0_we", WE, 1);
    wait_done(5, n);
    tick();

    // Back-to-back NONE: two DONE pulses
    d0 = done_cnt;
    issue(K_NONE, 5'd1, 1'b0, 32'h0);
    chk("none1_done", {DONE, RES_READY}, 2'b11);
    issue(K_NONE, 5'd2, 1'b0, 32'h0);
    chk("none2_done", DONE, 1);
    tick();
    chk("none_two_pulses", done_cnt - d0, 2);
    chk("err_sticky", ERR, 1);

    // Reset mid-WAIT_MEM, data pulse during and after reset: nothing written
    issue(K_LOAD, 5'd4, 1'b0, 32'h0);
    tick();
    #2 RST_N = 1'b0;
    #1;
    chk("async_reset_outputs", {RES_READY, RX_READY, WE, WADDR, FWADDR, WDATA, INE, INDATA, DONE, ERR}, 0);
    MEM_RVALID = 1'b1; MEM_RDATA = 32'hBAD0BAD0;
    tick();
    MEM_RVALID = 1'b0;
    tick();
    RST_N = 1'b1;
    MEM_RVALID = 1'b1;
    tick();
    MEM_RVALID = 1'b0;
    repeat (3) tick();
    chk("post_reset_state", {RES_READY, WE, DONE, ERR, WADDR}, {1'b1, 1'b0, 1'b0, 1'b0, 5'd0});

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
